// File: rtl/seq_pkg.sv
// seq_pkg: states, opcodes, IR field positions and control-bit indices for datapath_sequencer
package seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_ERR} state_t;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
    OP_ROR, OP_ROL, OP_NEG, OP_NOT, OP_MUL, OP_DIV
  } op_t;
  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  localparam int CI_HI = 7;
  localparam int CI_LO = 6;
  localparam int CI_PC = 5;
  localparam int CI_IR = 4;
  localparam int CI_Y = 3;
  localparam int CI_Z = 2;
  localparam int CI_MAR = 1;
  localparam int CI_MDR = 0;
  localparam int CO_HI = 7;
  localparam int CO_LO = 6;
  localparam int CO_ZH = 5;
  localparam int CO_ZL = 4;
  localparam int CO_PC = 3;
  localparam int CO_MDR = 2;
  localparam int CO_INP = 1;
  localparam int CO_C = 0;
  localparam logic [4:0] ALU_ADD_BIT = 5'd13;
  // ADD sits at the MSB of alu_op, so later opcodes move toward bit 0
  function automatic logic [13:0] alu_onehot(input logic [4:0] op);
    return 14'd1 << (ALU_ADD_BIT - op);
  endfunction
endpackage

// File: rtl/seq_reg_decode.sv
// seq_reg_decode: 4-to-16 one-hot register select with enable
module seq_reg_decode (
  input  logic        en_i,
  input  logic [3:0]  sel_i,
  output logic [15:0] onehot_o
);
  assign onehot_o = en_i ? 16'd1 << sel_i : '0;
endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: Moore control unit sequencing fetch/decode/ALU execute on the bus datapath.
// SEQ_MEM_WAIT_EN adds mem_ready and stretches T1 until memory data is valid.
module datapath_sequencer
  import seq_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] IR,
`ifdef SEQ_MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [7:0]  ctl_in,
  output logic [7:0]  ctl_out,
  output logic        IncPC,
  output logic        Read,
  output logic [13:0] alu_op,
  output logic        busy,
  output logic        done,
  output logic        err
);
  state_t     state_q;
  logic       err_q;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       legal, unary, muldiv;
  logic       t0, t1, t2, t3, t4, t5;
  logic       unused_ir;
  assign op = IR[OP_HI:OP_LO];
  assign ra = IR[RA_HI:RA_LO];
  assign rb = IR[RB_HI:RB_LO];
  assign rc = IR[RC_HI:RC_LO];
  assign unused_ir = ^IR[RC_LO-1:0];
  assign legal = op <= OP_DIV;
  assign unary = op == OP_NEG || op == OP_NOT;
  assign muldiv = op == OP_MUL || op == OP_DIV;
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: state_q <= start ? S_T0 : S_IDLE;
        S_T0: state_q <= S_T1;
`ifdef SEQ_MEM_WAIT_EN
        S_T1: state_q <= mem_ready ? S_T2 : S_T1;
`else
        S_T1: state_q <= S_T2;
`endif
        S_T2: state_q <= S_T3;
        S_T3: begin
          state_q <= legal ? S_T4 : S_ERR;
          err_q <= !legal;
        end
        S_T4: state_q <= S_T5;
        S_T5: state_q <= start ? S_T0 : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  // Execute-phase strobes are gated by legal so an illegal T3 drives nothing
  assign t0 = state_q == S_T0;
  assign t1 = state_q == S_T1;
  assign t2 = state_q == S_T2;
  assign t3 = state_q == S_T3 && legal;
  assign t4 = state_q == S_T4 && legal;
  assign t5 = state_q == S_T5 && legal;
  seq_reg_decode u_rout (
    .en_i     (t3 | t4),
    .sel_i    (t4 && !unary ? rc : rb),
    .onehot_o (Rout)
  );
  seq_reg_decode u_rin (
    .en_i     (t5 && !muldiv),
    .sel_i    (ra),
    .onehot_o (Rin)
  );
  always_comb begin
    ctl_in = '0;
    ctl_in[CI_HI] = t5 && muldiv;
    ctl_in[CI_LO] = t5 && muldiv;
    ctl_in[CI_PC] = t0;
    ctl_in[CI_IR] = t2;
    ctl_in[CI_Y] = t3;
    ctl_in[CI_Z] = t4;
    ctl_in[CI_MAR] = t0;
    ctl_in[CI_MDR] = t1;
    ctl_out = '0;
    ctl_out[CO_HI] = 1'b0;
    ctl_out[CO_LO] = 1'b0;
    ctl_out[CO_ZH] = 1'b0;
    ctl_out[CO_ZL] = t5 && !muldiv;
    ctl_out[CO_PC] = t0;
    ctl_out[CO_MDR] = t2;
    ctl_out[CO_INP] = 1'b0;
    ctl_out[CO_C] = 1'b0;
  end
  assign IncPC = t0;
  assign Read = t1;
  assign alu_op = t4 ? alu_onehot(op) : '0;
  assign busy = state_q != S_IDLE;
  assign done = t5;
  assign err = err_q;
  assert property (@(posedge clock) disable iff (clear) $onehot0({Rout, ctl_out}));
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: directed tests with a trace-queue reference model of the instruction sequence
module tb_datapath_sequencer;
  typedef struct packed {
    logic [15:0] rin, rout;
    logic [7:0]  ci, co;
    logic        inc, rd;
    logic [13:0] alu;
    logic        busy, done, err;
  } obs_t;
  logic clock = 1'b0, clear = 1'b1, start = 1'b0;
  logic [31:0] IR = '0;
`ifdef SEQ_MEM_WAIT_EN
  logic mem_ready = 1'b1;
`endif
  logic [15:0] Rin, Rout;
  logic [7:0] ctl_in, ctl_out;
  logic IncPC, Read, busy, done, err;
  logic [13:0] alu_op;
  obs_t act;
  obs_t q[$];
  bit lastq[$];
  obs_t rec[1:16];
  int n_checks = 0, n_fail = 0;
  always #5 clock = ~clock;
  datapath_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .IR(IR),
`ifdef SEQ_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .Rin(Rin), .Rout(Rout), .ctl_in(ctl_in), .ctl_out(ctl_out), .IncPC(IncPC),
    .Read(Read), .alu_op(alu_op), .busy(busy), .done(done), .err(err)
  );
  assign act = {Rin, Rout, ctl_in, ctl_out, IncPC, Read, alu_op, busy, done, err};
  task automatic check(input string name, input logic [66:0] got, input logic [66:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask
  function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
    return {op[4:0], ra[3:0], rb[3:0], rc[3:0], 15'd0};
  endfunction
  function automatic obs_t cyc(input int rin, input int rout, input int ci, input int co,
                               input bit inc, input bit rd, input int alu, input bit d, input bit e);
    return {rin[15:0], rout[15:0], ci[7:0], co[7:0], inc, rd, alu[13:0], 1'b1, d, e};
  endfunction
  // Expected per-cycle outputs of one whole instruction, built from the instruction's fields
  task automatic push_trace(input logic [31:0] ir);
    int op = int'(ir[31:27]);
    int ra = int'(ir[26:23]);
    int rb = int'(ir[22:19]);
    int rc = int'(ir[18:15]);
    q.push_back(cyc(0, 0, 'h22, 'h08, 1, 0, 0, 0, 0)); lastq.push_back(0);
    q.push_back(cyc(0, 0, 'h01, 0, 0, 1, 0, 0, 0)); lastq.push_back(0);
    q.push_back(cyc(0, 0, 'h10, 'h04, 0, 0, 0, 0, 0)); lastq.push_back(0);
    if (op > 12) begin
      q.push_back(cyc(0, 0, 0, 0, 0, 0, 0, 0, 0)); lastq.push_back(0);
      q.push_back(cyc(0, 0, 0, 0, 0, 0, 0, 0, 1)); lastq.push_back(0);
    end else begin
      q.push_back(cyc(0, 1 << rb, 'h08, 0, 0, 0, 0, 0, 0)); lastq.push_back(0);
      q.push_back(cyc(0, 1 << ((op == 9 || op == 10) ? rb : rc), 'h04, 0, 0, 0, 1 << (13 - op), 0, 0));
      lastq.push_back(0);
      if (op == 11 || op == 12) q.push_back(cyc(0, 0, 'hC0, 0, 0, 0, 0, 1, 0));
      else q.push_back(cyc(1 << ra, 0, 0, 'h10, 0, 0, 0, 1, 0));
      lastq.push_back(1);
    end
  endtask
  always @(posedge clock or posedge clear) begin : model
    bit restart;
    if (clear) begin
      q.delete();
      lastq.delete();
    end else begin
      restart = 1'b1;
      if (q.size() > 0) begin
        void'(q.pop_front());
        restart = lastq.pop_front();
      end
      if (q.size() == 0 && restart && start) push_trace(IR);
    end
  end
  always @(negedge clock) check("cycle", act, q.size() > 0 ? q[0] : '0);
  task automatic run_instr(input logic [31:0] ir, input int hold, input int n, output int lat);
    IR = ir;
    start = 1'b1;
    lat = 0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clock);
      #1;
      if (c == hold) start = 1'b0;
      rec[c] = act;
      if (act.done && lat == 0) lat = c;
    end
  endtask
  initial begin
    int lat, ndone, bad;
    #12;
    check("reset_outputs", act, '0);
    @(posedge clock);
    #1 clear = 1'b0;
    // clear in the middle of T4
    IR = mk(0, 1, 2, 3);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("pre_clear_T4_alu", act.alu, 14'h2000);
    clear = 1'b1;
    #1;
    check("clear_outputs", act, '0);
    @(posedge clock);
    #1 clear = 1'b0;
    check("after_clear_busy", {act.busy, act.err}, 2'b00);
    @(posedge clock);
    #1;
    check("after_clear_idle", act, '0);
    // ADD R1,R2,R3
    check("add_encoding", mk(0, 1, 2, 3), 32'h0091_8000);
    run_instr(32'h0091_8000, 1, 8, lat);
    check("add_latency", lat, 6);
    check("add_T0", {rec[1].co, rec[1].ci, rec[1].inc}, {8'h08, 8'h22, 1'b1});
    check("add_T3", {rec[4].rout, rec[4].ci}, {16'h0004, 8'h08});
    check("add_T4", {rec[5].rout, rec[5].alu, rec[5].ci}, {16'h0008, 14'h2000, 8'h04});
    check("add_T5", {rec[6].co, rec[6].rin, rec[6].done}, {8'h10, 16'h0002, 1'b1});
    check("add_idle_after", rec[7].busy, 1'b0);
    // MUL R0,R4,R5
    run_instr(mk(11, 0, 4, 5), 1, 8, lat);
    check("mul_latency", lat, 6);
    check("mul_T4", {rec[5].rout, rec[5].alu}, {16'h0020, 14'h0004});
    check("mul_T5", {rec[6].ci, rec[6].rin, rec[6].co, rec[6].done}, {8'hC0, 16'h0000, 8'h00, 1'b1});
    // NOT R6,R7 (Rc field set to 9 to show it is ignored)
    run_instr(mk(10, 6, 7, 9), 1, 8, lat);
    check("not_T4", {rec[5].rout, rec[5].alu}, {16'h0080, 14'h0008});
    check("not_T5_rin", rec[6].rin, 16'h0040);
    // ADD R3,R3,R3 and ADD R0 destination
    run_instr(mk(0, 3, 3, 3), 1, 8, lat);
    check("same_reg_T5", rec[6].rin, 16'h0008);
    run_instr(mk(1, 0, 1, 2), 1, 8, lat);
    check("r0_write", {rec[6].rin, rec[5].alu}, {16'h0001, 14'h1000});
    // start held: back-to-back ADDs
    run_instr(32'h0091_8000, 7, 16, lat);
    ndone = 0;
    for (int c = 1; c <= 16; c++) ndone += int'(rec[c].done);
    check("b2b_first_done", lat, 6);
    check("b2b_second_T0", {rec[7].co, rec[7].busy}, {8'h08, 1'b1});
    check("b2b_second_done", rec[12].done, 1'b1);
    check("b2b_done_count", ndone, 2);
    check("b2b_idle_after", rec[13].busy, 1'b0);
    // illegal opcode 20
    run_instr(mk(20, 1, 2, 3), 1, 8, lat);
    bad = 0;
    for (int c = 1; c <= 8; c++) bad += int'(rec[c].rin != 0) + int'(rec[c].ci[2]) + int'(rec[c].done);
    check("illegal_T3_silent", {rec[4].rout, rec[4].ci, rec[4].busy, rec[4].err}, {16'h0, 8'h0, 1'b1, 1'b0});
    check("illegal_err", {rec[5].err, rec[5].busy}, 2'b11);
    check("illegal_err_one_cycle", {rec[6].err, rec[6].busy}, 2'b00);
    check("illegal_no_writes", bad, 0);
    // restart after error works normally
    run_instr(mk(2, 5, 6, 7), 1, 8, lat);
    check("post_err_latency", lat, 6);
    check("post_err_T5", {rec[6].rin, rec[5].alu}, {16'h0020, 14'h0800});
    repeat (2) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
